mul_div_seq_array: RTL and testbench
====================================

// Module: mul_div_seq_array
// PURPOSE
//  Iterative, parametrised unsigned multiply/divide unit built from one shared row of
//  controlled add/subtract cells, evaluated R rows per clock.
//  MUL_BAR selects shift-add multiply (0) or non-restoring divide (1).
//  Sits between the operand register file and the result bus of the arithmetic datapath.
//  Replaces the fully unrolled combinational cell array with a START/BUSY/DONE handshake.
// PARAMETERS
//  WIDTH           8  operand width N in bits; WIDTH >= 2
//  ROWS_PER_CYCLE  1  array rows evaluated per clock (R); must divide WIDTH exactly
// PORTS
//  CLK          in   1        rising-edge clock
//  RST          in   1        asynchronous, active-high reset
//  START        in   1        request; sampled only in IDLE or DONE state
//  MUL_BAR      in   1        0 = multiply, 1 = divide; captured with START
//  X_IN         in   WIDTH    multiplicand / dividend; captured with START
//  Y_IN         in   WIDTH    multiplier / divisor; captured with START
//  BUSY         out  1        high from the accepted START edge until DONE
//  DONE         out  1        one-cycle pulse; results valid
//  PRODUCT      out  2*WIDTH  multiply result
//  QUOTIENT     out  WIDTH    divide result
//  REMAINDER    out  WIDTH    divide result; always < divisor
//  DIV_ZERO     out  1        set with DONE when divisor == 0
// BEHAVIOUR
//  - Reset: all outputs 0 and state IDLE, effective immediately; a reset mid-operation
//    aborts it with no DONE.
//  - States:
//    - IDLE --START--> RUN.
//    - RUN --last row--> CORR (divide) or FIN (multiply).
//    - CORR --> FIN.
//    - FIN --> DONE.
//    - DONE --START--> RUN; DONE --no START--> IDLE.
//  - Divide by zero bypasses RUN: IDLE --START, Y_IN == 0--> FIN.
//  - Row counter runs 0 .. WIDTH/R-1 and advances by one per RUN cycle.
//    Each cycle applies R rows, row i consuming bit i of Y (mul) or the next dividend bit (div).
//  - Latency, with START accepted at edge t, DONE is high in the cycle following edge t+L:
//    - multiply: L = WIDTH/R + 1
//    - divide: L = WIDTH/R + 2 (one extra remainder-correction cycle)
//    - divide by zero: L = 1
//  - Multiply:
//    - Accumulator is 2*WIDTH bits wide, so the product never overflows.
//    - Rows add X shifted into place when the Y bit is 1; the carry chain ripples across the row.
//  - Divide, non-restoring:
//    - Partial remainder is WIDTH+1 bits wide, signed.
//    - Each row subtracts Y if the current partial remainder >= 0, otherwise adds Y.
//    - The quotient bit is the inverse of the resulting sign.
//    - CORR adds Y back when the final remainder is negative.
//  - Divide by zero: QUOTIENT = all ones, REMAINDER = X_IN, DIV_ZERO = 1, PRODUCT = 0.
//  - Output holding:
//    - PRODUCT, QUOTIENT, REMAINDER and DIV_ZERO are registered.
//    - They hold from DONE until the next accepted START, then clear to 0 in the same edge.
//    - In multiply mode QUOTIENT and REMAINDER are 0; in divide mode PRODUCT is 0.
//  - START while BUSY is ignored and does not affect the running operation.
//  - START during the DONE cycle is accepted: back-to-back, BUSY stays high with no IDLE
//    cycle, and the new operands are captured.
//  - Operand or MUL_BAR changes after capture have no effect.
// STRUCTURE
//  - Shared package mul_div_pkg:
//    - state encoding (IDLE, RUN, CORR, FIN, DONE)
//    - MODE_MUL = 1'b0, MODE_DIV = 1'b1
//    - helper function clog2 for the row-counter width.
//  - Sub-module md_cell_row #(WIDTH):
//    - combinational row of WIDTH+1 controlled add/subtract cells
//    - inputs: partial, operand, MUL_BAR, row control; outputs: sum row and carry-out.
//  - The top instantiates ROWS_PER_CYCLE copies of md_cell_row in a generate chain,
//    plus the FSM, row counter and result registers.
// TESTING  (WIDTH=8, R=1 unless stated)
//  1. MUL_BAR=0, X=13, Y=11, START at edge 0 -> BUSY high from edge 0, DONE in the cycle
//     after edge 9, PRODUCT=143, QUOTIENT=0.
//  2. MUL_BAR=0, X=255, Y=255 -> PRODUCT=65025; then R=2 rerun -> DONE after edge 5,
//     same PRODUCT.
//  3. MUL_BAR=1, X=200, Y=7 -> DONE after edge 10, QUOTIENT=28, REMAINDER=4, DIV_ZERO=0;
//     also X=5, Y=9 -> Q=0, R=5.
//  4. MUL_BAR=1, X=100, Y=0 -> DONE after edge 1, QUOTIENT=255, REMAINDER=100, DIV_ZERO=1.
//  5. START re-asserted with new operands while BUSY -> ignored, first result correct;
//     START held in the DONE cycle -> second op accepted, BUSY never drops.
//  6. RST pulsed mid-RUN at edge 4 -> outputs 0 immediately, no DONE.
//     Next START completes with correct result.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   state_e    : controller state encoding (IDLE, RUN, CORR, FIN, DONE)
//   MODE_MUL   : MUL_BAR value selecting shift-add multiply
//   MODE_DIV   : MUL_BAR value selecting non-restoring divide
//   clog2()    : bits needed to count 0 .. value-1, never less than 1
package mul_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_CORR = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/md_cell_row.sv
// One row of WIDTH+1 controlled add/subtract cells with a rippling carry chain.
//   partial   in  WIDTH+1  partial product / partial remainder entering the row
//   operand   in  WIDTH    multiplicand (multiply) or divisor (divide), zero-extended
//   mul_bar   in  1        0 = multiply row, 1 = divide row
//   ctrl      in  1        multiply: add operand when 1, pass through when 0
//                          divide:   subtract operand when 1, add when 0
//   sum       out WIDTH+1  row result
//   carry_out out 1        carry leaving the most significant cell
module md_cell_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] operand,
    input  logic             mul_bar,
    input  logic             ctrl,
    output logic [WIDTH:0]   sum,
    output logic             carry_out
);
    logic             sub;
    logic             en;
    logic [WIDTH:0]   op_ext;
    logic [WIDTH+1:0] carry;

    // Subtraction is add of the inverted operand with carry-in 1.
    // In multiply mode the operand is gated by ctrl and never inverted.
    assign sub      = mul_bar & ctrl;
    assign en       = mul_bar | ctrl;
    assign op_ext   = {1'b0, operand};
    assign carry[0] = sub;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
        logic b;
        assign b          = (op_ext[i] & en) ^ sub;
        assign sum[i]     = partial[i] ^ b ^ carry[i];
        assign carry[i+1] = (partial[i] & b) | (partial[i] & carry[i]) | (b & carry[i]);
    end

    assign carry_out = carry[WIDTH+1];

endmodule

// File: rtl/mul_div_seq_array.sv
// Iterative unsigned multiply / non-restoring divide unit. ROWS_PER_CYCLE cell rows
// are chained combinationally and the chain is applied once per RUN cycle.
//   CLK, RST            clock, asynchronous active-high reset
//   START               request, accepted only in IDLE or DONE
//   MUL_BAR, X_IN, Y_IN mode and operands, captured on the accepting edge
//   BUSY                high in every non-IDLE state (stays high across back-to-back ops)
//   DONE                one-cycle pulse, results valid
//   PRODUCT             2*WIDTH multiply result (0 in divide mode)
//   QUOTIENT, REMAINDER divide results (0 in multiply mode)
//   DIV_ZERO            divisor was zero
//   dbg_state           current controller state
//
// Handshake: START is a request sampled on a rising edge while the unit is in
// IDLE or DONE; that edge captures the operands, clears all result registers
// and raises BUSY. While BUSY and not DONE, START is ignored. DONE is high for
// exactly one cycle with results valid; results then hold until the next
// accepted START. START high during DONE starts the next operation with no gap.
module mul_div_seq_array
    import mul_div_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               MUL_BAR,
    input  logic [WIDTH-1:0]   X_IN,
    input  logic [WIDTH-1:0]   Y_IN,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic [WIDTH-1:0]   QUOTIENT,
    output logic [WIDTH-1:0]   REMAINDER,
    output logic               DIV_ZERO,
    output state_e             dbg_state
);
    localparam int ROW_STEPS = WIDTH / ROWS_PER_CYCLE;
    localparam int CNT_W     = clog2(ROW_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_STEPS - 1);

    state_e             state_q, state_d;
    logic               mode_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   operand_q;
    // hi_q/lo_q are shared: multiply keeps {product high, multiplier shifting out},
    // divide keeps {signed partial remainder, dividend shifting out / quotient in}.
    logic [WIDTH:0]     hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               start_div_zero;
    logic               last_step;

    assign accept         = START && (state_q == ST_IDLE || state_q == ST_DONE);
    assign start_div_zero = (MUL_BAR == MODE_DIV) && (Y_IN == '0);
    assign last_step      = (cnt_q == CNT_LAST);
    assign dbg_state      = state_q;

    // ---------------- controller ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        BUSY    = (state_q != ST_IDLE);
        DONE    = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: if (START) state_d = start_div_zero ? ST_FIN : ST_RUN;
            ST_RUN:  if (last_step) state_d = (mode_q == MODE_DIV) ? ST_CORR : ST_FIN;
            ST_CORR: state_d = ST_FIN;
            ST_FIN:  state_d = ST_DONE;
            ST_DONE: begin
                if (START) state_d = start_div_zero ? ST_FIN : ST_RUN;
                else       state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- row chain ----------------
    logic [WIDTH:0]            chain_hi [ROWS_PER_CYCLE+1];
    logic [WIDTH-1:0]          chain_lo [ROWS_PER_CYCLE+1];
    logic [ROWS_PER_CYCLE-1:0] row_carry;
    logic                      unused_row_carry;

    assign chain_hi[0]      = hi_q;
    assign chain_lo[0]      = lo_q;
    // The row carry-out is always 0 in multiply mode and is discarded by the
    // modular remainder arithmetic in divide mode.
    assign unused_row_carry = ^row_carry;

    for (genvar k = 0; k < ROWS_PER_CYCLE; k++) begin : g_row
        logic [WIDTH:0] partial;
        logic [WIDTH:0] sum;
        logic           ctrl;

        // Divide: shift the next dividend bit into the remainder; subtract when
        // the remainder is non-negative. Multiply: add X when the Y bit is 1.
        assign partial = (mode_q == MODE_DIV) ? {chain_hi[k][WIDTH-1:0], chain_lo[k][WIDTH-1]}
                                              : {1'b0, chain_hi[k][WIDTH-1:0]};
        assign ctrl    = (mode_q == MODE_DIV) ? ~chain_hi[k][WIDTH] : chain_lo[k][0];

        md_cell_row #(.WIDTH(WIDTH)) u_row (
            .partial   (partial),
            .operand   (operand_q),
            .mul_bar   (mode_q),
            .ctrl      (ctrl),
            .sum       (sum),
            .carry_out (row_carry[k])
        );

        // Quotient bit is the inverse of the new remainder sign.
        assign chain_hi[k+1] = (mode_q == MODE_DIV) ? sum : {1'b0, sum[WIDTH:1]};
        assign chain_lo[k+1] = (mode_q == MODE_DIV) ? {chain_lo[k][WIDTH-2:0], ~sum[WIDTH]}
                                                    : {sum[0], chain_lo[k][WIDTH-1:1]};
    end

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q     <= MODE_MUL;
            div_zero_q <= 1'b0;
            operand_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            PRODUCT    <= '0;
            QUOTIENT   <= '0;
            REMAINDER  <= '0;
            DIV_ZERO   <= 1'b0;
        end else if (accept) begin
            mode_q     <= MUL_BAR;
            div_zero_q <= start_div_zero;
            operand_q  <= (MUL_BAR == MODE_DIV) ? Y_IN : X_IN;
            hi_q       <= '0;
            lo_q       <= (MUL_BAR == MODE_DIV) ? X_IN : Y_IN;
            cnt_q      <= '0;
            PRODUCT    <= '0;
            QUOTIENT   <= '0;
            REMAINDER  <= '0;
            DIV_ZERO   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    hi_q  <= chain_hi[ROWS_PER_CYCLE];
                    lo_q  <= chain_lo[ROWS_PER_CYCLE];
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_CORR: begin
                    if (hi_q[WIDTH]) hi_q <= hi_q + {1'b0, operand_q};
                end
                ST_FIN: begin
                    if (mode_q == MODE_MUL) begin
                        PRODUCT <= {hi_q[WIDTH-1:0], lo_q};
                    end else if (div_zero_q) begin
                        QUOTIENT  <= '1;
                        REMAINDER <= lo_q;
                        DIV_ZERO  <= 1'b1;
                    end else begin
                        QUOTIENT  <= lo_q;
                        REMAINDER <= hi_q[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_seq_array.sv
module tb_mul_div_seq_array;
  import mul_div_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start, mul_bar, sel;
  logic [W-1:0] x_in, y_in;
  logic         start1, start2;

  logic           busy1, done1, dz1, busy2, done2, dz2;
  logic [2*W-1:0] prod1, prod2;
  logic [W-1:0]   quo1, rem1, quo2, rem2;
  state_e         st1, st2;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  mul_div_seq_array #(.WIDTH(W), .ROWS_PER_CYCLE(1)) dut (
    .CLK(clk), .RST(rst), .START(start1), .MUL_BAR(mul_bar), .X_IN(x_in), .Y_IN(y_in),
    .BUSY(busy1), .DONE(done1), .PRODUCT(prod1), .QUOTIENT(quo1), .REMAINDER(rem1),
    .DIV_ZERO(dz1), .dbg_state(st1)
  );

  mul_div_seq_array #(.WIDTH(W), .ROWS_PER_CYCLE(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .MUL_BAR(mul_bar), .X_IN(x_in), .Y_IN(y_in),
    .BUSY(busy2), .DONE(done2), .PRODUCT(prod2), .QUOTIENT(quo2), .REMAINDER(rem2),
    .DIV_ZERO(dz2), .dbg_state(st2)
  );

  // the unit under test at the moment: sel=0 -> R=1, sel=1 -> R=2
  logic           cur_busy, cur_done, cur_dz;
  logic [2*W-1:0] cur_prod;
  logic [W-1:0]   cur_quo, cur_rem;
  state_e         cur_state;
  assign cur_busy  = sel ? busy2 : busy1;
  assign cur_done  = sel ? done2 : done1;
  assign cur_dz    = sel ? dz2   : dz1;
  assign cur_prod  = sel ? prod2 : prod1;
  assign cur_quo   = sel ? quo2  : quo1;
  assign cur_rem   = sel ? rem2  : rem1;
  assign cur_state = sel ? st2   : st1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  typedef struct {
    logic           mb;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic           dz;
    int             lat;
  } vec_t;

  // ---------------- driver tasks ----------------
  // Leaves the bench at the falling edge right after the accepting rising edge.
  task automatic start_op(input logic mb, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    mul_bar = mb;
    x_in    = x;
    y_in    = y;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until DONE is seen, bounded.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!cur_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!cur_done) check($sformatf("%s done_timeout", tag), 32'(cur_done), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    start_op(v.mb, v.x, v.y);
    check($sformatf("%s busy_after_start", tag), 32'(cur_busy), 32'd1);
    check($sformatf("%s prod_cleared", tag), 32'(cur_prod), 32'd0);
    check($sformatf("%s quo_cleared", tag), 32'(cur_quo), 32'd0);
    wait_done(tag, lat);
    check($sformatf("%s latency", tag), 32'(lat), 32'(v.lat));
    check($sformatf("%s product", tag), 32'(cur_prod), 32'(v.prod));
    check($sformatf("%s quotient", tag), 32'(cur_quo), 32'(v.quo));
    check($sformatf("%s remainder", tag), 32'(cur_rem), 32'(v.rem));
    check($sformatf("%s div_zero", tag), 32'(cur_dz), 32'(v.dz));
    @(negedge clk);
    check($sformatf("%s done_pulse", tag), 32'(cur_done), 32'd0);
    check($sformatf("%s idle_after", tag), 32'(cur_state), 32'(ST_IDLE));
    check($sformatf("%s hold_quo", tag), 32'(cur_quo), 32'(v.quo));
    check($sformatf("%s hold_prod", tag), 32'(cur_prod), 32'(v.prod));
  endtask

  // ---------------- test ----------------
  vec_t vecs[12];
  vec_t vecs2[4];

  initial begin
    int lat;
    int seen;
    rst     = 1'b1;
    start   = 1'b0;
    mul_bar = 1'b0;
    x_in    = '0;
    y_in    = '0;
    sel     = 1'b0;

    // mb, x, y, product, quotient, remainder, div_zero, latency (R=1)
    vecs[0]  = '{1'b0, 8'd13,  8'd11,  16'd143,   8'd0,   8'd0,   1'b0, 9};
    vecs[1]  = '{1'b0, 8'd255, 8'd255, 16'd65025, 8'd0,   8'd0,   1'b0, 9};
    vecs[2]  = '{1'b1, 8'd200, 8'd7,   16'd0,     8'd28,  8'd4,   1'b0, 10};
    vecs[3]  = '{1'b1, 8'd5,   8'd9,   16'd0,     8'd0,   8'd5,   1'b0, 10};
    vecs[4]  = '{1'b1, 8'd100, 8'd0,   16'd0,     8'd255, 8'd100, 1'b1, 1};
    vecs[5]  = '{1'b0, 8'd0,   8'd200, 16'd0,     8'd0,   8'd0,   1'b0, 9};
    vecs[6]  = '{1'b1, 8'd255, 8'd1,   16'd0,     8'd255, 8'd0,   1'b0, 10};
    vecs[7]  = '{1'b1, 8'd128, 8'd255, 16'd0,     8'd0,   8'd128, 1'b0, 10};
    vecs[8]  = '{1'b0, 8'd1,   8'd255, 16'd255,   8'd0,   8'd0,   1'b0, 9};
    vecs[9]  = '{1'b1, 8'd254, 8'd127, 16'd0,     8'd2,   8'd0,   1'b0, 10};
    vecs[10] = '{1'b0, 8'd200, 8'd0,   16'd0,     8'd0,   8'd0,   1'b0, 9};
    vecs[11] = '{1'b1, 8'd0,   8'd5,   16'd0,     8'd0,   8'd0,   1'b0, 10};

    // R=2 unit
    vecs2[0] = '{1'b0, 8'd255, 8'd255, 16'd65025, 8'd0,   8'd0,   1'b0, 5};
    vecs2[1] = '{1'b1, 8'd200, 8'd7,   16'd0,     8'd28,  8'd4,   1'b0, 6};
    vecs2[2] = '{1'b1, 8'd77,  8'd0,   16'd0,     8'd255, 8'd77,  1'b1, 1};
    vecs2[3] = '{1'b0, 8'd13,  8'd11,  16'd143,   8'd0,   8'd0,   1'b0, 5};

    // reset state
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset done", 32'(done1), 32'd0);
    check("reset product", 32'(prod1), 32'd0);
    check("reset quotient", 32'(quo1), 32'd0);
    check("reset remainder", 32'(rem1), 32'd0);
    check("reset div_zero", 32'(dz1), 32'd0);
    check("reset state", 32'(st1), 32'(ST_IDLE));
    check("reset busy r2", 32'(busy2), 32'd0);
    rst = 1'b0;

    // directed table, R=1
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // START re-asserted with new operands while BUSY is ignored
    start_op(1'b0, 8'd13, 8'd11);
    repeat (3) @(negedge clk);
    mul_bar = 1'b1;
    x_in    = 8'd1;
    y_in    = 8'd2;
    start   = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", lat);
    check("busy_start latency", 32'(lat + 5), 32'd9);
    check("busy_start product", 32'(prod1), 32'd143);
    check("busy_start quotient", 32'(quo1), 32'd0);
    check("busy_start div_zero", 32'(dz1), 32'd0);

    // back-to-back: START during the DONE cycle, operands changed after capture
    start_op(1'b0, 8'd13, 8'd11);
    exp_q.push_back(16'd143);
    wait_done("b2b first", lat);
    check("b2b first latency", 32'(lat), 32'd9);
    check("b2b first product", 32'(prod1), 32'(exp_q.pop_front()));
    check("b2b busy in done", 32'(busy1), 32'd1);
    mul_bar = 1'b1;
    x_in    = 8'd200;
    y_in    = 8'd7;
    start   = 1'b1;
    exp_q.push_back({8'd28, 8'd4});
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    mul_bar = 1'b0;
    x_in    = 8'd3;
    y_in    = 8'd0;
    check("b2b busy held", 32'(busy1), 32'd1);
    check("b2b no second done", 32'(done1), 32'd0);
    check("b2b state run", 32'(st1), 32'(ST_RUN));
    check("b2b product cleared", 32'(prod1), 32'd0);
    wait_done("b2b second", lat);
    check("b2b second latency", 32'(lat), 32'd10);
    check("b2b second result", 32'({quo1, rem1}), 32'(exp_q.pop_front()));
    check("b2b second product", 32'(prod1), 32'd0);
    check("b2b queue empty", 32'(exp_q.size()), 32'd0);

    // reset mid-RUN aborts without DONE
    start_op(1'b0, 8'd255, 8'd255);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun rst busy", 32'(busy1), 32'd0);
    check("midrun rst state", 32'(st1), 32'(ST_IDLE));
    check("midrun rst product", 32'(prod1), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done1) seen++;
    end
    check("midrun no done", 32'(seen), 32'd0);
    run_vec(vecs[0], "after_rst");

    // reset while a result is held clears it at once
    #2 rst = 1'b1;
    #1;
    check("held rst product", 32'(prod1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // R=2 unit
    sel = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(vecs2[i], $sformatf("r2vec%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
